// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time loader in front of the 8-bit Memory write port. A byte stream
// arriving over a valid/ready handshake is written to consecutive Memory
// addresses starting at START_ADDR. The CPU is held in reset (cpu_hold=1)
// and the Memory write port belongs to this block until the image has been
// completely written.
//
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, the byte carrying in_last is a modulo-256 checksum of the
//   written bytes rather than data. A match finishes the load normally; a
//   mismatch (or running off the top address) parks the loader in ERROR with
//   the CPU still held. Adds the checksum_err output.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   in_valid     in_data / in_last valid this cycle
//   in_data      byte to load
//   in_last      final byte of the image
//   in_ready     loader accepts a byte this cycle (LOAD only)
//   mem_we       one-cycle Memory write strobe
//   mem_addr     Memory write address
//   mem_wdata    Memory write data
//   cpu_hold     1 = CPU kept in reset, loader owns the memory bus
//   done         load completed successfully (sticky)
//   overflow     image ran past the top address without in_last (sticky)
//   checksum_err checksum mismatch (sticky, checksum build only)
//   byte_count   number of bytes written to Memory
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  output logic              checksum_err,
`endif
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_overflow;
  logic [ADDR_W:0]   r_byte_count;

  logic [2:0]        w_next_state;
  logic              w_xfer;
  logic              w_at_top;
  logic              w_write;
  logic              w_ovf;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  logic              r_checksum_err;
  logic              w_ck_xfer;
  logic              w_ck_bad;
`endif

  // -------------------------------------------------------------------------
  // Transfer decode and next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_xfer   = (r_state == ST_LOAD) && r_in_ready && in_valid;
    w_at_top = (r_addr == '1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // The in_last byte is the checksum and never reaches Memory.
    w_ck_xfer = w_xfer && in_last;
    w_ck_bad  = w_ck_xfer && (in_data[7:0] != r_sum);
    w_write   = w_xfer && !in_last;
    w_ovf     = w_write && w_at_top;
`else
    w_write   = w_xfer;
    w_ovf     = w_xfer && w_at_top && !in_last;
`endif

    w_next_state = r_state;
    case (r_state)
      ST_INIT: begin
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (w_ck_bad || w_ovf) begin
          w_next_state = ST_ERROR;
        end else if (w_ck_xfer) begin
          w_next_state = ST_DRAIN;
        end
`else
        // Forced end at the top address finishes the load like in_last.
        if (w_xfer && (in_last || w_at_top)) begin
          w_next_state = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: begin
        w_next_state = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        w_next_state = r_state;
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_addr       <= START_ADDR;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_state    <= w_next_state;
      // Registered ready: asserted exactly while the next state is LOAD.
      r_in_ready <= (w_next_state == ST_LOAD);
      r_mem_we   <= w_write;

      if (w_write) begin
        r_mem_addr   <= r_addr;
        r_mem_wdata  <= in_data;
        r_byte_count <= r_byte_count + 1'b1;
        // The address counter saturates at the top instead of wrapping.
        if (!w_at_top) begin
          r_addr <= r_addr + 1'b1;
        end
      end

      if (w_ovf) begin
        r_overflow <= 1'b1;
      end

      if (w_next_state == ST_DONE) begin
        r_cpu_hold <= 1'b0;
        r_done     <= 1'b1;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum          <= '0;
      r_checksum_err <= 1'b0;
    end else begin
      if (w_write) begin
        r_sum <= r_sum + in_data[7:0];
      end
      if (w_ck_bad) begin
        r_checksum_err <= 1'b1;
      end
    end
  end

  assign checksum_err = r_checksum_err;
`endif

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign byte_count = r_byte_count;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader that sits directly upstream of the 8-bit Memory, sharing its write port with the CPU.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive Memory addresses.
- Holds the CPU in reset (cpu_hold) until the image is fully written, then releases it.
- The top-level muxes Memory's writeEnable/Address/WriteData to this block while cpu_hold=1.

Parameters:
- ADDR_W, 8, width of Memory address bus and address counter
- DATA_W, 8, width of data bytes
- START_ADDR, 0, first Memory address written after reset

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- in_valid  input  1  in_data/in_last valid this cycle
- in_data  input  DATA_W  byte to load
- in_last  input  1  marks final byte of image
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  one-cycle Memory write strobe
- mem_addr  output  ADDR_W  Memory write address
- mem_wdata  output  DATA_W  Memory write data
- cpu_hold  output  1  1 = keep CPU in reset / own memory bus
- done  output  1  load completed successfully (sticky)
- overflow  output  1  image ran past address 2^ADDR_W-1 without in_last (sticky)
- byte_count  output  ADDR_W+1  number of bytes written to Memory

Behaviour:
- Reset (reset=0 at clk edge): state=INIT, addr counter=START_ADDR; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, overflow=0, byte_count=0. Reset wins over every other input. Memory contents already written are not cleared.
- States: INIT -> LOAD (unconditional, 1 cycle); LOAD -> DRAIN on accepting a final byte; DRAIN -> DONE (unconditional); DONE and ERROR hold until reset.
- All outputs are registered; in_ready=1 only in LOAD.
- Transfer: occurs when in_valid=1 and in_ready=1 at a clk edge.
- Write latency: exactly one cycle. The cycle after a transfer, mem_we=1, mem_addr=counter value at transfer, mem_wdata=in_data. mem_we=0 in all other cycles.
- Throughput: back-to-back transfers are allowed, one byte per cycle; counter and byte_count increment by 1 per written byte.
- Final byte: a transfer with in_last=1, or a transfer at counter = 2^ADDR_W-1 (forced end). A forced end with in_last=0 sets overflow=1; the byte is still written and the load still finishes.
- In DRAIN, in_ready=0 while the final write strobe is on the bus. On entry to DONE: cpu_hold=0, done=1. The counter does not wrap.
- In DONE: in_valid is ignored, in_ready=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
- Reset mid-load: returns to INIT immediately; any pending write strobe is dropped.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit modulo-256 running sum of written bytes is kept, reset to 0.
  - The byte transferred with in_last=1 is a checksum: it is NOT written (no mem_we, counter and byte_count unchanged).
  - On match with the running sum: go to DRAIN, then DONE.
  - On mismatch: go to ERROR, with cpu_hold=1, done=0, in_ready=0, and output checksum_err=1 (extra 1-bit port, reset 0).
  - A forced end at the top address takes no checksum, sets overflow=1 and goes to ERROR.
- Without the macro: no sum logic, no checksum_err port, and the in_last byte is ordinary data.

Test Plan:
- Reset held 3 cycles, then released -> cycle 1 after release: in_ready=0, cpu_hold=1; cycle 2: in_ready=1; all other outputs 0.
- Stream 0x11,0x22,0x33 back-to-back, last on 0x33 (macro off) -> mem_we pulses at addr 0,1,2 with those data on consecutive cycles; byte_count=3; cpu_hold=0 and done=1 one cycle after the 0x33 write; in_ready=0 thereafter.
- in_valid toggled 1,0,1 with bytes 0xA0,0xA1 -> exactly two writes (addr 0 and 1), no strobe in the idle cycle.
- 256 bytes with in_last never set -> final write at addr 0xFF, overflow=1, done=1, byte_count=256, no write to addr 0x00 afterwards.
- Reset asserted the cycle after a transfer, mid-stream -> no mem_we in the following cycle, state INIT, byte_count=0, cpu_hold=1.
- Macro on: data 0x01,0x02, checksum 0x03 -> two writes, done=1. Repeat with checksum 0x04 -> checksum_err=1, cpu_hold stays 1, done=0.
